// File: rtl/filter_sequencer_if.sv
// Signal bundle between the sample sequencer and its ADC, filter and DAC neighbours.
// master: sequencer side; slave: environment side.
interface filter_sequencer_if;
    logic        syncADC;
    logic [11:0] adcSample;
    logic [11:0] filterSample;
    logic        highPassSinkValid;
    logic        lowPassSinkValid;
    logic [11:0] highPassOutput;
    logic [11:0] lowPassOutput;
    logic        highPassOutValid;
    logic        lowPassOutValid;
    logic [1:0]  highPassError;
    logic [1:0]  lowPassError;
    logic [3:0]  highGain;
    logic [3:0]  lowGain;
    logic [11:0] dacData;
    logic        dacValid;
    logic        clearFlags;
    logic        overrunFlag;
    logic        errorFlag;
    logic        timeoutFlag;

    modport master (
        input  syncADC, adcSample, highPassOutput, lowPassOutput, highPassOutValid,
               lowPassOutValid, highPassError, lowPassError, highGain, lowGain, clearFlags,
        output filterSample, highPassSinkValid, lowPassSinkValid, dacData, dacValid,
               overrunFlag, errorFlag, timeoutFlag
    );

    modport slave (
        output syncADC, adcSample, highPassOutput, lowPassOutput, highPassOutValid,
               lowPassOutValid, highPassError, lowPassError, highGain, lowGain, clearFlags,
        input  filterSample, highPassSinkValid, lowPassSinkValid, dacData, dacValid,
               overrunFlag, errorFlag, timeoutFlag
    );
endinterface

// File: rtl/filter_sequencer.sv
// Sequences one ADC sample through both FIR filters and mixes their results for the DAC.
// Define FILTER_TIMEOUT_EN to build the WAIT-state watchdog and a live timeoutFlag.
module filter_sequencer #(
    parameter int unsigned GAIN_FRAC      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 dacSerialClock,
    input logic                 resetN,
    filter_sequencer_if.master  bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StMult, StSat} state_e;

    state_e             state;
    logic [11:0]        filterSampleQ;
    logic               sinkValidQ;
    logic [11:0]        dacDataQ;
    logic               dacValidQ;
    logic               overrunQ;
    logic               errorQ;
    logic signed [11:0] hRes;
    logic signed [11:0] lRes;
    logic               hGot;
    logic               lGot;
    logic signed [16:0] pH;
    logic signed [16:0] pL;

    logic               hTake;
    logic               lTake;
    logic               bothDone;
    logic               timeoutHit;
    logic signed [16:0] pHNext;
    logic signed [16:0] pLNext;
    logic signed [17:0] sum;
    logic signed [17:0] shifted;
    logic [11:0]        clamped;
    logic               overrunSet;
    logic               errorSet;

    assign hTake    = (state == StWait) && bus.highPassOutValid;
    assign lTake    = (state == StWait) && bus.lowPassOutValid;
    assign bothDone = (hGot || hTake) && (lGot || lTake);

    // Gains are unsigned, so they enter the signed product with a zero sign bit.
    assign pHNext  = $signed({{5{hRes[11]}}, hRes}) * $signed({13'd0, bus.highGain});
    assign pLNext  = $signed({{5{lRes[11]}}, lRes}) * $signed({13'd0, bus.lowGain});
    assign sum     = $signed({pH[16], pH}) + $signed({pL[16], pL});
    assign shifted = sum >>> GAIN_FRAC;

    always_comb begin
        clamped = shifted[11:0];
        if (shifted > 18'sd2047) begin
            clamped = 12'h7FF;
        end else if (shifted < -18'sd2048) begin
            clamped = 12'h800;
        end
    end

    // A sync landing on the SAT->IDLE edge still counts as an overrun.
    assign overrunSet = bus.syncADC && (state != StIdle);
    assign errorSet   = (hTake && (|bus.highPassError)) || (lTake && (|bus.lowPassError));

`ifdef FILTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);

    logic [CntW-1:0] waitCnt;
    logic            timeoutQ;

    assign timeoutHit = (state == StWait) && !bothDone && (waitCnt == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge dacSerialClock or negedge resetN) begin
        if (!resetN) begin
            waitCnt  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            waitCnt <= (state == StWait) ? waitCnt + 1'b1 : '0;
            if (timeoutHit) begin
                timeoutQ <= 1'b1;
            end else if (bus.clearFlags) begin
                timeoutQ <= 1'b0;
            end
        end
    end

    assign bus.timeoutFlag = timeoutQ;
`else
    assign timeoutHit      = 1'b0;
    assign bus.timeoutFlag = 1'b0;
`endif

    always_ff @(posedge dacSerialClock or negedge resetN) begin
        if (!resetN) begin
            state         <= StIdle;
            filterSampleQ <= 12'h000;
            sinkValidQ    <= 1'b0;
            dacDataQ      <= 12'h800;
            dacValidQ     <= 1'b0;
            overrunQ      <= 1'b0;
            errorQ        <= 1'b0;
            hRes          <= '0;
            lRes          <= '0;
            hGot          <= 1'b0;
            lGot          <= 1'b0;
            pH            <= '0;
            pL            <= '0;
        end else begin
            sinkValidQ <= 1'b0;
            dacValidQ  <= 1'b0;

            if (overrunSet) begin
                overrunQ <= 1'b1;
            end else if (bus.clearFlags) begin
                overrunQ <= 1'b0;
            end
            if (errorSet) begin
                errorQ <= 1'b1;
            end else if (bus.clearFlags) begin
                errorQ <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (bus.syncADC) begin
                        filterSampleQ <= {~bus.adcSample[11], bus.adcSample[10:0]};
                        sinkValidQ    <= 1'b1;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
                    hGot  <= 1'b0;
                    lGot  <= 1'b0;
                    state <= StWait;
                end
                StWait: begin
                    if (hTake) begin
                        hRes <= bus.highPassOutput;
                        hGot <= 1'b1;
                    end
                    if (lTake) begin
                        lRes <= bus.lowPassOutput;
                        lGot <= 1'b1;
                    end
                    if (bothDone || timeoutHit) begin
                        state <= StMult;
                    end
                end
                StMult: begin
                    pH    <= pHNext;
                    pL    <= pLNext;
                    state <= StSat;
                end
                StSat: begin
                    dacDataQ  <= {~clamped[11], clamped[10:0]};
                    dacValidQ <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.filterSample      = filterSampleQ;
    assign bus.highPassSinkValid = sinkValidQ;
    assign bus.lowPassSinkValid  = sinkValidQ;
    assign bus.dacData           = dacDataQ;
    assign bus.dacValid          = dacValidQ;
    assign bus.overrunFlag       = overrunQ;
    assign bus.errorFlag         = errorQ;

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer: vector table, hand-written corner sequences
// and randomized samples against an arithmetic mixing model.
module tb_filter_sequencer;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    int   dvCount;

    logic [11:0] expHold;
    logic [11:0] lastH;
    logic [11:0] lastL;

    filter_sequencer_if bus ();

    filter_sequencer dut (
        .dacSerialClock (clk),
        .resetN         (rstN),
        .bus            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.dacValid === 1'b1) dvCount++;

    typedef struct {
        logic [11:0] adc;
        logic [11:0] h;
        logic [11:0] l;
        logic [3:0]  hg;
        logic [3:0]  lg;
        int          dh;
        int          dl;
        logic [11:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Mix computed as real arithmetic: weighted sum / 2^3 rounded toward -inf, clamped,
    // then shifted into offset binary.
    function automatic logic [11:0] mixModel(input logic [11:0] h, input logic [11:0] l,
                                             input int hg, input int lg);
        int s;
        s = int'($signed(h)) * hg + int'($signed(l)) * lg;
        s = (s >= 0) ? s / 8 : -((-s + 7) / 8);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return 12'(s + 2048);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic runSample(input vec_t v, input string name);
        int dv0;
        int last;
        dv0  = dvCount;
        last = (v.dh > v.dl) ? v.dh : v.dl;
        bus.highGain  = v.hg;
        bus.lowGain   = v.lg;
        bus.adcSample = v.adc;
        bus.syncADC   = 1'b1;
        tick();
        bus.syncADC = 1'b0;
        check({name, " hp sink valid"}, 32'(bus.highPassSinkValid), 32'd1);
        check({name, " lp sink valid"}, 32'(bus.lowPassSinkValid), 32'd1);
        check({name, " filterSample"}, 32'(bus.filterSample), 32'(v.adc ^ 12'h800));
        for (int t = 0; t <= last; t++) begin
            tick();
            if (t == 0) check({name, " sink valid drop"}, 32'(bus.highPassSinkValid), 32'd0);
            check({name, " no early dacValid"}, 32'(bus.dacValid), 32'd0);
            bus.highPassOutValid = (t == v.dh);
            bus.lowPassOutValid  = (t == v.dl);
            bus.highPassOutput   = (t == v.dh) ? v.h : 12'($urandom);
            bus.lowPassOutput    = (t == v.dl) ? v.l : 12'($urandom);
        end
        lastH = v.h;
        lastL = v.l;
        for (int t = 1; t <= 2; t++) begin
            tick();
            bus.highPassOutValid = 1'b0;
            bus.lowPassOutValid  = 1'b0;
            check({name, " dacValid low"}, 32'(bus.dacValid), 32'd0);
            check({name, " dacData held"}, 32'(bus.dacData), 32'(expHold));
        end
        tick();
        check({name, " dacValid"}, 32'(bus.dacValid), 32'd1);
        check({name, " dacData"}, 32'(bus.dacData), 32'(v.exp));
        expHold = v.exp;
        tick();
        check({name, " dacValid one cycle"}, 32'(bus.dacValid), 32'd0);
        check({name, " dacData hold"}, 32'(bus.dacData), 32'(expHold));
        check({name, " dacValid count"}, 32'(dvCount - dv0), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        checks  = 0;
        errors  = 0;
        dvCount = 0;
        expHold = 12'h800;
        lastH   = '0;
        lastL   = '0;
        rstN    = 1'b0;
        bus.syncADC = 0; bus.adcSample = 0; bus.highPassOutput = 0; bus.lowPassOutput = 0;
        bus.highPassOutValid = 0; bus.lowPassOutValid = 0; bus.highPassError = 0;
        bus.lowPassError = 0; bus.highGain = 0; bus.lowGain = 0; bus.clearFlags = 0;

        vecs[0] = '{12'hC00, 12'd100, 12'd200, 4'd8, 4'd8, 0, 0, 12'h92C};
        vecs[1] = '{12'h123, 12'd2047, 12'd2047, 4'd15, 4'd15, 1, 1, 12'hFFF};
        vecs[2] = '{12'h000, 12'h800, 12'h800, 4'd15, 4'd15, 2, 0, 12'h000};
        vecs[3] = '{12'hFFF, -12'sd100, 12'd50, 4'd8, 4'd4, 0, 2, 12'h7B5};
        vecs[4] = '{12'h7FF, 12'd7, 12'd0, 4'd1, 4'd0, 0, 0, 12'h800};
        vecs[5] = '{12'h801, -12'sd9, 12'd0, 4'd1, 4'd0, 1, 0, 12'h7FE};
        vecs[6] = '{12'h400, 12'd40, 12'd24, 4'd2, 4'd3, 4, 0, 12'h813};
        vecs[7] = '{12'h555, 12'd3, 12'd300, 4'd0, 4'd0, 0, 3, 12'h800};

        repeat (3) tick();
        rstN = 1'b1;
        tick();
        check("reset dacData", 32'(bus.dacData), 32'h800);
        check("reset dacValid", 32'(bus.dacValid), 32'd0);
        check("reset filterSample", 32'(bus.filterSample), 32'd0);
        check("reset sink valid", 32'({bus.highPassSinkValid, bus.lowPassSinkValid}), 32'd0);
        check("reset flags", 32'({bus.overrunFlag, bus.errorFlag, bus.timeoutFlag}), 32'd0);

        for (int i = 0; i < 8; i++) runSample(vecs[i], $sformatf("vec%0d", i));

        // Overrun in WAIT, clear racing a set, error code, overrun on SAT->IDLE edge.
        bus.highGain = 4'd8; bus.lowGain = 4'd8; bus.adcSample = 12'h000;
        bus.syncADC = 1'b1;
        tick();
        bus.syncADC = 1'b0;
        tick();
        bus.syncADC = 1'b1;
        tick();
        check("overrun set in WAIT", 32'(bus.overrunFlag), 32'd1);
        check("no sink valid on overrun", 32'(bus.highPassSinkValid), 32'd0);
        bus.clearFlags = 1'b1;
        tick();
        bus.syncADC = 1'b0; bus.clearFlags = 1'b0;
        check("set wins over clear", 32'(bus.overrunFlag), 32'd1);
        check("no sink valid after overrun", 32'(bus.lowPassSinkValid), 32'd0);
        bus.highPassOutValid = 1'b1; bus.lowPassOutValid = 1'b1;
        bus.highPassOutput = 12'd16; bus.lowPassOutput = 12'd16; bus.highPassError = 2'b01;
        lastH = 12'd16; lastL = 12'd16;
        tick();
        bus.highPassOutValid = 1'b0; bus.lowPassOutValid = 1'b0; bus.highPassError = 2'b00;
        check("errorFlag set", 32'(bus.errorFlag), 32'd1);
        bus.clearFlags = 1'b1;
        tick();
        bus.clearFlags = 1'b0;
        check("flags cleared", 32'({bus.overrunFlag, bus.errorFlag}), 32'd0);
        bus.syncADC = 1'b1;
        tick();
        bus.syncADC = 1'b0;
        check("error sample dacValid", 32'(bus.dacValid), 32'd1);
        check("error sample dacData", 32'(bus.dacData), 32'(mixModel(12'd16, 12'd16, 8, 8)));
        expHold = mixModel(12'd16, 12'd16, 8, 8);
        check("overrun on SAT exit", 32'(bus.overrunFlag), 32'd1);
        tick();
        check("SAT exit sync ignored", 32'(bus.highPassSinkValid), 32'd0);
        bus.clearFlags = 1'b1;
        tick();
        bus.clearFlags = 1'b0;

        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v.adc = 12'($urandom);
            v.h   = (i % 7 == 0) ? 12'h800 : 12'($urandom);
            v.l   = (i % 5 == 0) ? 12'h7FF : 12'($urandom);
            v.hg  = 4'($urandom);
            v.lg  = 4'($urandom);
            v.dh  = $urandom_range(0, 3);
            v.dl  = $urandom_range(0, 3);
            v.exp = mixModel(v.h, v.l, int'(v.hg), int'(v.lg));
            runSample(v, $sformatf("rand%0d", i));
        end
        check("no stray flags", 32'({bus.overrunFlag, bus.errorFlag}), 32'd0);

`ifdef FILTER_TIMEOUT_EN
        begin
            logic [11:0] expT;
            int          waited;
            bus.highGain = 4'd5; bus.lowGain = 4'd3;
            expT = mixModel(lastH, 12'd77, 5, 3);
            bus.syncADC = 1'b1;
            tick();
            bus.syncADC = 1'b0;
            tick();
            bus.lowPassOutValid = 1'b1; bus.lowPassOutput = 12'd77;
            tick();
            bus.lowPassOutValid = 1'b0;
            waited = 0;
            while (bus.dacValid !== 1'b1 && waited < 400) begin
                tick();
                waited++;
            end
            check("timeout dacValid seen", 32'(bus.dacValid), 32'd1);
            check("timeout dacData", 32'(bus.dacData), 32'(expT));
            check("timeoutFlag", 32'(bus.timeoutFlag), 32'd1);
            expHold = expT;
            bus.clearFlags = 1'b1;
            tick();
            bus.clearFlags = 1'b0;
        end
`else
        check("timeoutFlag tied low", 32'(bus.timeoutFlag), 32'd0);
`endif

        // Reset while waiting on the filters abandons the sample.
        begin
            int dv0;
            dv0 = dvCount;
            bus.syncADC = 1'b1;
            tick();
            bus.syncADC = 1'b0;
            tick();
            tick();
            rstN = 1'b0;
            tick();
            rstN = 1'b1;
            expHold = 12'h800;
            bus.highPassOutValid = 1'b1; bus.lowPassOutValid = 1'b1;
            tick();
            bus.highPassOutValid = 1'b0; bus.lowPassOutValid = 1'b0;
            repeat (6) tick();
            check("reset mid-op no dacValid", 32'(dvCount - dv0), 32'd0);
            check("reset mid-op dacData", 32'(bus.dacData), 32'(expHold));
            check("reset mid-op idle", 32'(bus.highPassSinkValid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
# filter_sequencer

Sample sequencer between the ADC packager, the two FIR filters and the DAC packager. On each ADC sync pulse it captures the 12-bit ADC sample and issues one sink-valid strobe to both the high-pass and low-pass filters. It then collects both filter outputs and forms a gain-weighted mix. The mix is saturated, converted to offset binary and presented to the DAC block with a one-cycle valid strobe.

## Interface
Parameters:
- GAIN_FRAC, 3, fractional bits of the gain inputs; a gain of 2^GAIN_FRAC is unity.
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit; used only when FILTER_TIMEOUT_EN is defined.

Ports:
- dacSerialClock  in  1  sole clock, the same clock as the filters.
- resetN  in  1  asynchronous, active-low reset.
- syncADC  in  1  one-cycle pulse: adcSample is valid.
- adcSample  in  12  ADC sample, offset binary.
- filterSample  out  12  sample to both filters: adcSample with MSB inverted (two's complement).
- highPassSinkValid, lowPassSinkValid  out  1  one-cycle filter input strobes.
- highPassOutput, lowPassOutput  in  12  filter results, signed.
- highPassOutValid, lowPassOutValid  in  1  filter result strobes.
- highPassError, lowPassError  in  2  filter error codes.
- highGain, lowGain  in  4  unsigned channel gains.
- dacData  out  12  mixed sample, offset binary.
- dacValid  out  1  one-cycle strobe: dacData updated.
- clearFlags  in  1  synchronous clear of sticky flags.
- overrunFlag, errorFlag, timeoutFlag  out  1  sticky status flags.

## Operation
- States: IDLE, ISSUE, WAIT, MULT, SAT.
- IDLE: on syncADC, register filterSample and go to ISSUE.
- ISSUE: drive both sink-valid outputs high for exactly this cycle, then go to WAIT.
- WAIT: capture each filter result independently on its OutValid.
  - The two results may arrive in either order or in the same cycle.
  - Once a result is captured, a repeat OutValid on that channel before the state exits overwrites it.
  - Leave for MULT once both results are captured.
- Error: an OutValid with a nonzero error code sets errorFlag. The data is still used.
- MULT: register pH = highPassOutput × {0,highGain} and pL = lowPassOutput × {0,lowGain}.
  - Operands are 12-bit signed × 5-bit signed; products are 17-bit signed.
- SAT: form s = (pH + pL), 18-bit signed, then arithmetic shift right by GAIN_FRAC.
  - Clamp s to the range [-2048, 2047].
  - Register dacData = clamped value with MSB inverted. Set dacValid = 1 for the next cycle.
  - Return to IDLE.
- Overrun: a syncADC outside IDLE sets overrunFlag and is ignored.
  - Exception: a syncADC in the same cycle as the SAT→IDLE transition is also an overrun. IDLE samples syncADC only while already in IDLE.
- Flags: clearFlags clears all sticky flags. A set event in the same cycle as clearFlags wins.
- Reset values: state IDLE; filterSample 0; all strobes 0; dacData 12'h800 (mid-scale); all flags 0; captured results 0.
- Reset mid-operation abandons the sample. No dacValid is emitted for it.

## Timing
- syncADC high in cycle 0 → sink-valid outputs high in cycle 1, with filterSample already stable in cycle 1.
- Last filter result captured in cycle k → MULT in cycle k+1, SAT in cycle k+2, dacValid high and new dacData in cycle k+3.
- dacData holds its value between dacValid strobes.
- Minimum syncADC spacing without overrun is (filter latency + 5) cycles.

## Configuration
- FILTER_TIMEOUT_EN defined:
  - A WAIT counter runs from 0. When it reaches TIMEOUT_CYCLES without both results captured, timeoutFlag is set.
  - The missing channel uses its last captured value and the state proceeds to MULT.
  - The counter clears on entry to WAIT.
- FILTER_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - timeoutFlag is tied to 0 and no counter is built.

## Test plan
- Reset release, then syncADC with adcSample=12'hC00 → filterSample=12'h400, both sink valids high for one cycle at cycle 1. dacData reads 12'h800 until the first dacValid.
- Gains 8/8, highPassOutput=100 and lowPassOutput=200, both valid same cycle k → dacValid at k+3, dacData=12'h92C.
- Saturation: gains 15/15, both outputs 2047 → dacData=12'hFFF. Both outputs -2048 → dacData=12'h000.
- Out-of-order arrival: lowPassOutValid at k, highPassOutValid at k+4 → exactly one dacValid, at k+7.
- syncADC pulsed in WAIT → overrunFlag=1 and no extra sink valid. Same-cycle syncADC and clearFlags → flag stays 1. Error code 2'b01 on an OutValid → errorFlag=1.
- With FILTER_TIMEOUT_EN: suppress highPassOutValid → timeoutFlag=1 and dacValid follows using the held high-pass value. resetN low during WAIT → state IDLE and no dacValid.
